// File: rtl/jk_updown_counter.sv
// jk_updown_counter: synchronous mod-MODULUS up/down counter built from a bank
// of JK storage cells. The excitation stage derives the next count, turns it
// into per-bit J/K pairs (exported as j_vec/k_vec), and the cells apply JK
// semantics on the rising clock edge.
//
// Build option: define JK_COUNTER_SATURATE_EN to make counting stop at the
// range limits (0 going down, MODULUS-1 going up) instead of wrapping.

// Single JK storage cell. q_bar is taken from the same flop as q so the pair
// can never disagree.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    logic state;

    // JK update: 00 hold, 01 clear, 10 set, 11 toggle; reset clears at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   state <= 1'b0;
                2'b10:   state <= 1'b1;
                2'b11:   state <= ~state;
                default: state <= state;
            endcase
        end
    end

    assign q     = state;
    assign q_bar = ~state;

endmodule

module jk_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec
);

    // MODULUS may equal 2^WIDTH, so range checks on load_val use one extra bit.
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_updown_counter: MODULUS must lie in 2..2^WIDTH");
    end

    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_dec;
    logic             at_max;
    logic             at_zero;

    assign q_inc   = q + WIDTH'(1);
    assign q_dec   = q - WIDTH'(1);
    assign at_max  = (q == MAX_CNT);
    assign at_zero = (q == '0);

    // Next-count selection: load beats count, count beats hold.
    always_comb begin
        n = q;
        if (load) begin
            // Out-of-range loads clamp to 0 so the count never leaves range.
            n = ({1'b0, load_val} < MOD_EXT) ? load_val : '0;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
`ifdef JK_COUNTER_SATURATE_EN
                    n = q;
`else
                    n = '0;
`endif
                end else if (q > MAX_CNT) begin
                    // Corrupted state going up recovers to 0.
                    n = '0;
                end else begin
                    n = q_inc;
                end
            end else begin
                if (at_zero) begin
`ifdef JK_COUNTER_SATURATE_EN
                    n = q;
`else
                    n = MAX_CNT;
`endif
                end else if (q_dec > MAX_CNT) begin
                    // Corrupted state going down lands on the top of range.
                    n = MAX_CNT;
                end else begin
                    n = q_dec;
                end
            end
        end
    end

    // Excitation: set bits that must rise, clear bits that must fall.
    // 11 is never produced; 00 whenever n == q.
    assign j_vec = ~q & n;
    assign k_vec = q & ~n;

    // Terminal count marks the cycle the limit is crossed (or held at, when
    // saturating); a load in the same cycle suppresses it.
    assign tc = en & ~load & (up ? at_max : at_zero);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j_vec[i]),
            .k     (k_vec[i]),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed bench for jk_updown_counter (WIDTH=4, MODULUS=10).
module tb_jk_updown_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic [3:0] q_bar;
    logic       tc;
    logic [3:0] j_vec;
    logic [3:0] k_vec;

    int checks;
    int failures;

    typedef struct {
        logic       ld;
        logic       en;
        logic       up;
        logic [3:0] lv;
        logic       tc;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] qn;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .q_bar    (q_bar),
        .tc       (tc),
        .j_vec    (j_vec),
        .k_vec    (k_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Drive one vector mid-cycle, check combinational outputs, then check the
    // registered count after the next rising edge.
    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        load     = v.ld;
        en       = v.en;
        up       = v.up;
        load_val = v.lv;
        #1;
        chk({nm, ".tc"}, {31'd0, tc}, {31'd0, v.tc});
        chk({nm, ".j"}, {28'd0, j_vec}, {28'd0, v.j});
        chk({nm, ".k"}, {28'd0, k_vec}, {28'd0, v.k});
        @(posedge clk);
        #1;
        chk({nm, ".q"}, {28'd0, q}, {28'd0, v.qn});
        chk({nm, ".q_bar"}, {28'd0, q_bar}, {28'd0, ~v.qn});
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Up count from 1 to 9 (no wrap yet). Fields: ld en up lv | tc j k qn
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0010, 4'b0001, 4'd2});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0001, 4'b0000, 4'd3});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0100, 4'b0011, 4'd4});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0001, 4'b0000, 4'd5});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0010, 4'b0001, 4'd6});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0001, 4'b0000, 4'd7});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b1000, 4'b0111, 4'd8});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0001, 4'b0000, 4'd9});

        // Loads, clamps, hold and small counts, starting from q=2.
        tbl_b.push_back('{1'b1, 1'b1, 1'b1, 4'd5,  1'b0, 4'b0101, 4'b0010, 4'd5});
        tbl_b.push_back('{1'b1, 1'b1, 1'b1, 4'd12, 1'b0, 4'b0000, 4'b0101, 4'd0});
        tbl_b.push_back('{1'b1, 1'b1, 1'b0, 4'd3,  1'b0, 4'b0011, 4'b0000, 4'd3});
        tbl_b.push_back('{1'b1, 1'b0, 1'b0, 4'd10, 1'b0, 4'b0000, 4'b0011, 4'd0});
        tbl_b.push_back('{1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 4'b0000, 4'b0000, 4'd0});
        tbl_b.push_back('{1'b1, 1'b0, 1'b1, 4'd9,  1'b0, 4'b1001, 4'b0000, 4'd9});
        tbl_b.push_back('{1'b1, 1'b1, 1'b0, 4'd6,  1'b0, 4'b0110, 4'b1001, 4'd6});
        tbl_b.push_back('{1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'b0000, 4'b0000, 4'd6});
        tbl_b.push_back('{1'b0, 1'b0, 1'b1, 4'd3,  1'b0, 4'b0000, 4'b0000, 4'd6});
        tbl_b.push_back('{1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'b0000, 4'b0000, 4'd6});
        tbl_b.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'b0000, 4'b0000, 4'd6});
        tbl_b.push_back('{1'b0, 1'b0, 1'b0, 4'd9,  1'b0, 4'b0000, 4'b0000, 4'd6});
        tbl_b.push_back('{1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 4'b0001, 4'b0000, 4'd7});
        tbl_b.push_back('{1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'b0000, 4'b0001, 4'd6});
        tbl_b.push_back('{1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'b0001, 4'b0010, 4'd5});

        // Reset state with no clock edge yet.
        reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 4'd0;
        #3;
        chk("rst.q", {28'd0, q}, 32'h0);
        chk("rst.q_bar", {28'd0, q_bar}, 32'hF);
        chk("rst.tc", {31'd0, tc}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Async reset mid-cycle at q=7, then counting restarts from 0.
        apply('{1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 4'b0111, 4'b0000, 4'd7}, "ld7");
        @(negedge clk);
        load = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("async_rst.q", {28'd0, q}, 32'h0);
        chk("async_rst.q_bar", {28'd0, q_bar}, 32'hF);
        #1 reset = 1'b0;
        apply('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0001, 4'b0000, 4'd1}, "post_rst");

        foreach (tbl_a[i]) apply(tbl_a[i], $sformatf("upA[%0d]", i));

`ifdef JK_COUNTER_SATURATE_EN
        // Saturate at 9 going up, at 0 going down; tc stays high at the limit.
        apply('{1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'b0000, 4'b0000, 4'd9}, "sat_up0");
        apply('{1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'b0000, 4'b0000, 4'd9}, "sat_up1");
        apply('{1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'b0000, 4'b0000, 4'd9}, "sat_up2");
        apply('{1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 4'b0000, 4'b1000, 4'd1}, "sat_ld1");
        apply('{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, 4'b0001, 4'd0}, "sat_dn0");
        apply('{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'b0000, 4'b0000, 4'd0}, "sat_dn1");
        apply('{1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 4'b0010, 4'b0000, 4'd2}, "sat_ld2");
`else
        // Up wrap 9->0 then 1,2; down wrap 0->9 then 8.
        apply('{1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'b0000, 4'b1001, 4'd0}, "wrap_up");
        apply('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0001, 4'b0000, 4'd1}, "wrap_up1");
        apply('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0010, 4'b0001, 4'd2}, "wrap_up2");
        apply('{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, 4'b0010, 4'd0}, "ld0");
        apply('{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'b1001, 4'b0000, 4'd9}, "wrap_dn");
        apply('{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, 4'b0001, 4'd8}, "wrap_dn1");
        apply('{1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 4'b0010, 4'b1000, 4'd2}, "ld2");
`endif

        foreach (tbl_b[i]) apply(tbl_b[i], $sformatf("tblB[%0d]", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
